// File: rtl/mux_rr_stream_if.sv
// Stream bundle for mux_rr_stream: N input channels with valid/ready plus one
// registered output channel. The slave modport is the multiplexer's view.
interface mux_rr_stream_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_rr_stream.sv
// N:1 streaming mux with one registered output stage, fixed-select or round-robin grant.
// Defining MUX_RR_STATS_EN adds a saturating 16-bit output-transfer counter (xfer_count).
module mux_rr_stream #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_rr_stream_if.slave       bus
`ifdef MUX_RR_STATS_EN
  ,
  output logic [15:0]          xfer_count
`endif
);

  logic [WIDTH-1:0]    outData_q, outData_d;
  logic [SEL_W-1:0]    outChan_q, outChan_d;
  logic                outValid_q, outValid_d;
  logic [SEL_W-1:0]    rrPtr_q, rrPtr_d;

  logic                loadEn;
  logic                grantValid;
  logic [SEL_W-1:0]    grantIdx;
  logic [SEL_W-1:0]    cand;
  logic                xfer;
  logic [CHANNELS-1:0] inReady;

  assign loadEn = !outValid_q | bus.out_ready;

  // Round-robin starts one past the last served channel and wraps around.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    if (!bus.mode) begin
      cand = bus.sel;
      if ((int'(bus.sel) < CHANNELS) && bus.in_valid[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = SEL_W'((int'(rrPtr_q) + k) % CHANNELS);
        if (!grantValid && bus.in_valid[cand]) begin
          grantValid = 1'b1;
          grantIdx   = cand;
        end
      end
    end
  end

  assign xfer = grantValid & loadEn;

  always_comb begin
    inReady = '0;
    if (xfer && !rst) begin
      inReady[grantIdx] = 1'b1;
    end
  end

  assign bus.in_ready = inReady;

  always_comb begin
    outData_d  = outData_q;
    outChan_d  = outChan_q;
    outValid_d = outValid_q;
    rrPtr_d    = rrPtr_q;
    if (xfer) begin
      outData_d  = bus.in_data[int'(grantIdx)*WIDTH +: WIDTH];
      outChan_d  = grantIdx;
      outValid_d = 1'b1;
      rrPtr_d    = grantIdx;
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData_q  <= '0;
      outChan_q  <= '0;
      outValid_q <= 1'b0;
      rrPtr_q    <= SEL_W'(CHANNELS - 1);
    end else begin
      outData_q  <= outData_d;
      outChan_q  <= outChan_d;
      outValid_q <= outValid_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_chan  = outChan_q;
  assign bus.out_valid = outValid_q;

`ifdef MUX_RR_STATS_EN
  logic [15:0] xferCount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xferCount_q <= '0;
    end else if (outValid_q && bus.out_ready && (xferCount_q != 16'hFFFF)) begin
      xferCount_q <= xferCount_q + 16'd1;
    end
  end

  assign xfer_count = xferCount_q;
`endif

endmodule
